// File: rtl/kd_run_sequencer.sv
// Steps KD_top through the Run_mode codes of one NTT/INTT operation, advancing on done_flag
// levels and aborting when a single phase exceeds TIMEOUT_CYC cycles.
module kd_run_sequencer #(
  parameter int TIMEOUT_CYC = 4095,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kd_sel,
  input  logic             inv,
  input  logic [1:0]       done_flag,
  output logic [3:0]       Run_mode,
  output logic             KD_mode,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             err_sticky,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_FINISH, S_ABORT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       run_mode_q, run_mode_d;
  logic             kd_mode_q, kd_mode_d;
  logic             inv_q, inv_d;
  logic             step_q, step_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    phase_q, phase_d;

  logic             phase_masked_s;
  logic             phase_expired_s;
  logic             last_step_s;
  logic [CNT_W-1:0] cnt_inc_s;

  // Compute-phase code for a given step; the drain code is always this plus one.
  function automatic logic [3:0] compute_code(input logic kd, input logic iv, input logic step);
    logic [3:0] code;
    case ({kd, iv})
      2'b00:   code = step ? 4'd3 : 4'd1;
      2'b01:   code = step ? 4'd7 : 4'd9;
      2'b10:   code = 4'd5;
      2'b11:   code = 4'd11;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  // Next-state and next-output computation.
  always_comb begin
    state_d    = state_q;
    run_mode_d = run_mode_q;
    kd_mode_d  = kd_mode_q;
    inv_d      = inv_q;
    step_d     = step_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    err_d      = err_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q + TW'(1);

    // A flag seen in the first cycle of a phase may still be the previous phase's level.
    phase_masked_s  = (phase_q == TW'(1));
    phase_expired_s = (phase_q == TW'(TIMEOUT_CYC));
    last_step_s     = kd_mode_q ? 1'b1 : step_q;
    cnt_inc_s       = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          kd_mode_d  = kd_sel;
          inv_d      = inv;
          step_d     = 1'b0;
          err_d      = 1'b0;
          run_mode_d = compute_code(kd_sel, inv, 1'b0);
          busy_d     = 1'b1;
          cnt_d      = CNT_W'(1);
          phase_d    = TW'(1);
        end else begin
          phase_d = TW'(0);
        end
      end
      S_RUN: begin
        if (!phase_masked_s && done_flag[0]) begin
          state_d    = S_DRAIN;
          run_mode_d = run_mode_q + 4'd1;
          phase_d    = TW'(1);
          cnt_d      = cnt_inc_s;
        end else if (phase_expired_s) begin
          state_d    = S_ABORT;
          run_mode_d = 4'd0;
          timeout_d  = 1'b1;
          err_d      = 1'b1;
          busy_d     = 1'b0;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      S_DRAIN: begin
        if (!phase_masked_s && done_flag[1]) begin
          if (last_step_s) begin
            state_d    = S_FINISH;
            run_mode_d = 4'd0;
            done_d     = 1'b1;
            busy_d     = 1'b0;
          end else begin
            state_d    = S_RUN;
            step_d     = 1'b1;
            run_mode_d = compute_code(kd_mode_q, inv_q, 1'b1);
            phase_d    = TW'(1);
            cnt_d      = cnt_inc_s;
          end
        end else if (phase_expired_s) begin
          state_d    = S_ABORT;
          run_mode_d = 4'd0;
          timeout_d  = 1'b1;
          err_d      = 1'b1;
          busy_d     = 1'b0;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      S_FINISH, S_ABORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        run_mode_d = 4'd0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      run_mode_q <= 4'd0;
      kd_mode_q  <= 1'b0;
      inv_q      <= 1'b0;
      step_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
      phase_q    <= {TW{1'b0}};
    end else begin
      state_q    <= state_d;
      run_mode_q <= run_mode_d;
      kd_mode_q  <= kd_mode_d;
      inv_q      <= inv_d;
      step_q     <= step_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
    end
  end

  assign Run_mode   = run_mode_q;
  assign KD_mode    = kd_mode_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign err_sticky = err_q;
  assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_kd_run_sequencer.sv
// Self-checking bench for kd_run_sequencer: directed table, random operations against a
// step-table reference model, and hand-written timeout / reset sequences.
module tb_kd_run_sequencer;

  localparam int TO = 4095;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, start, kd_sel, inv;
  logic [1:0]    done_flag;
  logic [3:0]    Run_mode;
  logic          KD_mode, busy, done, timeout, err_sticky;
  logic [CW-1:0] cycle_cnt;

  kd_run_sequencer #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .kd_sel(kd_sel), .inv(inv), .done_flag(done_flag),
    .Run_mode(Run_mode), .KD_mode(KD_mode), .busy(busy), .done(done), .timeout(timeout),
    .err_sticky(err_sticky), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  logic [31:0] got_seq;
  int          got_cnt, done_seen, to_seen, bad_busy, bad_kd, fin_idx;
  bit          finished, err_first;

  typedef struct {
    bit          kd;
    bit          iv;
    int          dc;
    int          dd;
    bit          stale;
    int          poke;
    logic [31:0] seq;
    int          cnt;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected code sequence straight from the step table, packed one nibble per code.
  function automatic logic [31:0] model_seq(input bit kd, input bit iv);
    int steps[$];
    logic [31:0] s;
    if (kd) steps.push_back(iv ? 11 : 5);
    else if (iv) begin steps.push_back(9); steps.push_back(7); end
    else begin steps.push_back(1); steps.push_back(3); end
    s = 32'd0;
    foreach (steps[i]) s = (s << 8) | 32'(steps[i] << 4) | 32'(steps[i] + 1);
    return s;
  endfunction

  // Each phase lasts until its flag is seen, but never shorter than 2 cycles.
  function automatic int model_cnt(input bit kd, input int dc, input int dd);
    int nsteps;
    nsteps = kd ? 1 : 2;
    return nsteps * ((dc < 2 ? 2 : dc) + (dd < 2 ? 2 : dd));
  endfunction

  task automatic run_op(input bit kd, input bit iv, input int dc, input int dd, input bit stale,
                        input int poke, input int budget);
    logic [3:0] rm_prev;
    int ph;
    int n;
    start = 1'b1; kd_sel = kd; inv = iv;
    tick();
    start = 1'b0;
    rm_prev = 4'd0; ph = 0; got_seq = 32'd0; got_cnt = -1;
    done_seen = 0; to_seen = 0; bad_busy = 0; bad_kd = 0; fin_idx = -1;
    finished = 1'b0; n = 0; err_first = err_sticky;
    while (!finished && n < budget) begin
      if (Run_mode !== rm_prev) begin
        ph = 1;
        if (Run_mode != 4'd0) got_seq = {got_seq[27:0], Run_mode};
      end else begin
        ph++;
      end
      rm_prev = Run_mode;
      if (busy !== (Run_mode != 4'd0)) bad_busy++;
      if (busy && KD_mode !== kd) bad_kd++;
      if (done === 1'b1) begin done_seen++; got_cnt = int'(cycle_cnt); finished = 1'b1; fin_idx = n; end
      if (timeout === 1'b1) begin to_seen++; got_cnt = int'(cycle_cnt); finished = 1'b1; fin_idx = n; end
      if (stale) done_flag = 2'b11;
      else begin
        done_flag[0] = Run_mode[0] && ph >= dc;
        done_flag[1] = (Run_mode != 4'd0) && !Run_mode[0] && ph >= dd;
      end
      start  = (n == poke) && busy;
      kd_sel = ~kd;
      inv    = ~iv;
      tick();
      n++;
    end
    start = 1'b0;
    if (!stale) done_flag = 2'b00;
    chk("op_terminated", finished, 1);
  endtask

  task automatic check_done_op(input string tag, input logic [31:0] seq, input int cnt);
    chk({tag, "_codes"}, got_seq, seq);
    chk({tag, "_done_pulses"}, done_seen, 1);
    chk({tag, "_timeouts"}, to_seen, 0);
    chk({tag, "_cycle_cnt"}, got_cnt, cnt);
    chk({tag, "_busy_track"}, bad_busy, 0);
    chk({tag, "_kd_mode"}, bad_kd, 0);
    chk({tag, "_done_after"}, done, 0);
    chk({tag, "_idle_mode"}, Run_mode, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int n;
    bit kd, iv;
    int dc, dd, pk;

    vecs[0] = '{1'b0, 1'b0, 30,   30,   1'b0, 10, 32'h1234, 120};
    vecs[1] = '{1'b0, 1'b1, 30,   30,   1'b0, -1, 32'h9A78, 120};
    vecs[2] = '{1'b1, 1'b0, 1024, 352,  1'b0, -1, 32'h56,   1376};
    vecs[3] = '{1'b1, 1'b1, 1024, 352,  1'b0, 50, 32'hBC,   1376};
    vecs[4] = '{1'b1, 1'b0, 1,    1,    1'b1, -1, 32'h56,   4};
    vecs[5] = '{1'b0, 1'b1, 1,    1,    1'b1, -1, 32'h9A78, 8};
    vecs[6] = '{1'b0, 1'b0, 1,    1,    1'b0, 1,  32'h1234, 8};

    rst = 1'b1; start = 1'b0; kd_sel = 1'b0; inv = 1'b0; done_flag = 2'b00;
    tick(); tick();
    chk("rst_run_mode", Run_mode, 0);
    chk("rst_kd_mode", KD_mode, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_cnt", cycle_cnt, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].kd, vecs[i].iv, vecs[i].dc, vecs[i].dd, vecs[i].stale, vecs[i].poke, 20000);
      check_done_op($sformatf("vec%0d", i), vecs[i].seq, vecs[i].cnt);
      done_flag = 2'b00;
      tick();
    end

    for (int i = 0; i < 16; i++) begin
      kd = 1'($urandom_range(0, 1));
      iv = 1'($urandom_range(0, 1));
      dc = $urandom_range(1, 40);
      dd = $urandom_range(1, 40);
      pk = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 30) : -1;
      run_op(kd, iv, dc, dd, 1'b0, pk, 2000);
      check_done_op($sformatf("rnd%0d", i), model_seq(kd, iv), model_cnt(kd, dc, dd));
      tick();
    end

    // Compute flag never rises: the RUN phase must abort after exactly TO cycles.
    run_op(1'b0, 1'b0, 1000000, 1, 1'b0, -1, 6000);
    chk("to_codes", got_seq, 32'h1);
    chk("to_pulse", to_seen, 1);
    chk("to_no_done", done_seen, 0);
    chk("to_index", fin_idx, TO);
    chk("to_cycle_cnt", got_cnt, TO);
    chk("to_pulse_width", timeout, 0);
    chk("to_err_held", err_sticky, 1);
    chk("to_idle_mode", Run_mode, 0);
    tick();
    run_op(1'b1, 1'b0, 3, 3, 1'b0, -1, 2000);
    chk("to_err_cleared", err_first, 0);
    check_done_op("after_to", 32'h56, 6);
    chk("after_to_err", err_sticky, 0);
    tick();

    // Reset during the first drain phase, with a simultaneous start that must lose to rst.
    start = 1'b1; kd_sel = 1'b0; inv = 1'b0;
    tick();
    start = 1'b0;
    done_flag = 2'b01;
    n = 0;
    while (Run_mode !== 4'd2 && n < 100) begin tick(); n++; end
    chk("rstmid_reached_drain", Run_mode, 2);
    start = 1'b1; kd_sel = 1'b1; inv = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("rstmid_busy_start_ignored", Run_mode, 2);
    chk("rstmid_kd_unchanged", KD_mode, 0);
    chk("rstmid_busy", busy, 1);
    rst = 1'b1; start = 1'b1;
    tick();
    chk("rstmid_mode", Run_mode, 0);
    chk("rstmid_busy_low", busy, 0);
    chk("rstmid_no_done", done, 0);
    chk("rstmid_cnt", cycle_cnt, 0);
    rst = 1'b0; start = 1'b0; done_flag = 2'b00;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (Run_mode != 4'd0 || done) n++;
    end
    chk("rstmid_stays_idle", n, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
